i2f_conv: RTL and testbench

- Converts a 32-bit integer (signed or unsigned) to an IEEE-754 single-precision value.
- Sits directly upstream of the floating-point multiplier and drives its A1/B1 operands, so integer sensor or counter data can enter the FP datapath.
- 3-stage pipeline with valid/ready handshake on both sides and a per-result inexact flag.

---
 rtl/fp_pkg.sv | 13 +
 rtl/lzc32.sv | 11 +
 rtl/i2f_conv.sv | 70 +++++++
 tb/tb_i2f_conv.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: IEEE-754 single-precision types and constants shared by the FP datapath stages.
package fp_pkg;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 127;
    localparam bit RND_RNE   = 1'b0;
    localparam bit RND_TRUNC = 1'b1;
    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;
endpackage

// File: rtl/lzc32.sv
// lzc32: combinational 32-bit leading-zero counter, returns 32 for a zero input.
module lzc32 (
    input  logic [31:0] data_i,
    output logic [5:0]  cnt_o
);
    always_comb begin
        cnt_o = 6'd32;
        for (int i = 0; i < 32; i++)
            if (data_i[i]) cnt_o = 6'(31 - i);
    end
endmodule

// File: rtl/i2f_conv.sv
// i2f_conv: 3-stage integer to IEEE-754 single converter (capture, normalise, round/pack)
// with valid/ready on both sides; a stalled output freezes the whole pipeline.
module i2f_conv
    import fp_pkg::*;
#(
    parameter int SIGNED   = 1,
    parameter int RND_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        inexact
);
    localparam bit RNE = (1'(RND_MODE) == RND_RNE);
    logic        v1_q, v2_q, out_valid_q, inexact_q, stall;
    logic        sign1_q, sign2_q, zero2_q, sign_d, inc, inexact_d;
    logic [31:0] mag1_q, mag_d, out_data_q;
    logic [30:0] norm2_q, norm_d;
    logic [5:0]  lz, lz2_q;
    logic [7:0]  exp_d;
    logic [23:0] frac_sum;
    fp32_t       res_d;
    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign inexact   = inexact_q;
    assign sign_d = (SIGNED != 0) && in_data[31];
    assign mag_d  = sign_d ? -in_data : in_data;
    lzc32 u_lzc (.data_i(mag1_q), .cnt_o(lz));
    // The leading one lands in bit 31 and is implicit, so only bits below it are kept.
    assign norm_d    = 31'(mag1_q << lz);
    assign exp_d     = 8'(FP_BIAS + 31) - {2'b00, lz2_q};
    assign inc       = RNE & norm2_q[7] & (|norm2_q[6:0] | norm2_q[8]);
    assign frac_sum  = {1'b0, norm2_q[30:8]} + {23'd0, inc};
    assign inexact_d = norm2_q[7] | (|norm2_q[6:0]);
    always_comb begin
        res_d.sign = sign2_q;
        res_d.exp  = zero2_q ? 8'd0 : exp_d + 8'(frac_sum[23]);
        res_d.frac = frac_sum[22:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            inexact_q   <= 1'b0;
        end else if (!stall) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            sign1_q     <= sign_d;
            mag1_q      <= mag_d;
            sign2_q     <= sign1_q;
            zero2_q     <= (mag1_q == 32'd0);
            lz2_q       <= lz;
            norm2_q     <= norm_d;
            if (v2_q) begin
                out_data_q <= res_d;
                inexact_q  <= inexact_d;
            end
        end
    end
endmodule

// File: tb/tb_i2f_conv.sv
// tb_i2f_conv: drives four i2f_conv configurations in lockstep and checks them against
// an arithmetic reference model, directed spec vectors, backpressure and mid-stream reset.
module tb_i2f_conv;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] in_data;
    logic        ir [4];
    logic        ov [4];
    logic        ix [4];
    logic [31:0] od [4];
    int          n_cmp = 0, n_err = 0, n_out = 0;
    logic [31:0] q[$];
    always #5 clk = ~clk;
    // Configurations k: 0 signed/RNE, 1 signed/trunc, 2 unsigned/RNE, 3 unsigned/trunc.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        i2f_conv #(.SIGNED(g < 2 ? 1 : 0), .RND_MODE(g % 2)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]),
            .in_data(in_data), .out_valid(ov[g]), .out_ready(out_ready),
            .out_data(od[g]), .inexact(ix[g])
        );
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic void model(input logic [31:0] x, input bit sg, input bit tr,
                                  output logic [31:0] r, output logic inx);
        bit     s;
        int     e;
        longint mag, m, rem, half;
        s   = sg && x[31];
        mag = s ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        r   = 32'h0;
        inx = 1'b0;
        if (mag == 0) return;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            m = mag << (23 - e); rem = 0; half = 1;
        end else begin
            m = mag >> (e - 23); rem = mag - (m << (e - 23)); half = 64'sd1 << (e - 24);
        end
        inx = (rem != 0);
        if (!tr && (rem > half || (rem == half && m[0]))) m++;
        if (m == (64'sd1 << 24)) begin m = m >> 1; e++; end
        r = {s, 8'(e + 127), 23'(m)};
    endfunction
    always @(negedge clk) begin
        logic [31:0] x, r;
        logic        inx;
        if (rst) q.delete();
        else begin
            if (in_valid && ir[0]) q.push_back(in_data);
            if (ov[0] && out_ready) begin
                n_out++;
                if (q.size() == 0) chk("extra_out", 32'd1, 32'd0);
                else begin
                    x = q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        model(x, k < 2, k % 2 == 1, r, inx);
                        chk($sformatf("data%0d(%h)", k, x), od[k], r);
                        chk($sformatf("inexact%0d(%h)", k, x), 32'(ix[k]), 32'(inx));
                    end
                end
            end
        end
    end
    task automatic send_one(input logic [31:0] x, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = x;
        @(posedge clk); #1;
        in_valid = 1'b0; lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (ov[0]) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask
    typedef struct packed {
        logic [31:0]      x;
        logic [3:0][31:0] d;
        logic [3:0]       i;
    } vec_t;
    vec_t vecs [7];
    function automatic logic [31:0] rnd_val();
        case ($urandom % 4)
            0: return $urandom;
            1: return $urandom % 256;
            2: return (32'd1 << ($urandom % 32)) + ($urandom % 5) - 2;
            default: return $urandom >> ($urandom % 32);
        endcase
    endfunction
    initial begin
        int lat, base, acc, cyc;
        vecs[0] = '{32'd11, {4{32'h41300000}}, 4'b0000};
        vecs[1] = '{32'hFFFFFFFF, {32'h4F7FFFFF, 32'h4F800000, 32'hBF800000, 32'hBF800000}, 4'b1100};
        vecs[2] = '{32'h0, {4{32'h0}}, 4'b0000};
        vecs[3] = '{32'h80000000, {32'h4F000000, 32'h4F000000, 32'hCF000000, 32'hCF000000}, 4'b0000};
        vecs[4] = '{32'd16777217, {4{32'h4B800000}}, 4'b1111};
        vecs[5] = '{32'd16777219, {32'h4B800001, 32'h4B800002, 32'h4B800001, 32'h4B800002}, 4'b1111};
        vecs[6] = '{32'd2147483647, {32'h4EFFFFFF, 32'h4F000000, 32'h4EFFFFFF, 32'h4F000000}, 4'b1111};
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_out_valid", 32'(ov[k]), 32'd0);
            chk("rst_out_data", od[k], 32'h0);
            chk("rst_inexact", 32'(ix[k]), 32'd0);
            chk("rst_in_ready", 32'(ir[k]), 32'd1);
        end
        rst = 1'b0;
        foreach (vecs[v]) begin
            send_one(vecs[v].x, lat);
            chk($sformatf("latency(%h)", vecs[v].x), lat, 3);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d_data%0d", v, k), od[k], vecs[v].d[k]);
                chk($sformatf("vec%0d_inexact%0d", v, k), 32'(ix[k]), 32'(vecs[v].i[k]));
            end
        end
        @(posedge clk); #1;
        base = n_out;
        fork
            begin
                bit ok;
                for (int i = 1; i <= 8; i++) begin
                    in_valid = 1'b1; in_data = i; ok = 1'b0;
                    for (int t = 0; t < 30 && !ok; t++) begin
                        @(negedge clk);
                        ok = ir[0];
                        @(posedge clk); #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                int w = 0;
                while (!ov[0] && w < 20) begin
                    @(posedge clk); #1;
                    w++;
                end
                chk("bp_out_valid_rise", 32'(ov[0]), 32'd1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    for (int k = 0; k < 4; k++) begin
                        chk("bp_in_ready", 32'(ir[k]), 32'd0);
                        chk("bp_hold_data", od[k], 32'h3F800000);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("bp_result_count", n_out - base, 8);
        chk("bp_queue_empty", q.size(), 0);
        in_valid = 1'b1; in_data = 32'd100;
        @(posedge clk); #1; in_data = 32'd200;
        @(posedge clk); #1; in_data = 32'd300;
        @(posedge clk); #1; in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 4; k++) chk("rst_mid_out_valid", 32'(ov[k]), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(ov[0]), 32'd0);
        end
        send_one(32'd5, lat);
        chk("rst_latency", lat, 3);
        for (int k = 0; k < 4; k++) chk("rst_next_data", od[k], 32'h40A00000);
        @(posedge clk); #1;
        acc = 0; cyc = 0;
        while (acc < 300 && cyc < 5000) begin
            in_valid = ($urandom % 4) != 0;
            in_data = rnd_val();
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            if (in_valid && ir[0]) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_accepted", acc, 300);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
